// File: rtl/pmod_adc_mirror.sv
// pmod_adc_mirror
//   SAR ADC controller for the PmodADC mirror setup. Each conversion tracks
//   the input (ADC_SH_o high), then runs a 14-bit successive-approximation
//   search: every trial word {trial, 2'b00} is shifted MSB first into the
//   ADC-chain DAC, latched, and judged by the external comparator after a
//   settling delay. The finished result is published on result_o and,
//   when the DAC_MIRROR_EN macro is defined, also shifted out on the DAC_*
//   mirror chain. Conversions repeat back to back.
//
//   Configuration macro: DAC_MIRROR_EN (undefined: DAC_* tied low and the
//   mirror frame is skipped).
//
// Ports
//   pin_clk_i      in   system clock, rising edge
//   reset_ni       in   synchronous reset, active low
//   ADC_SH_o       out  sample/hold: 1 = track, 0 = hold
//   ADC_Ser_o      out  ADC-chain serial data, MSB first
//   ADC_SClk_o     out  ADC-chain shift clock
//   ADC_LClk_o     out  ADC-chain latch strobe
//   ADC_Comp_i     in   comparator (async): 1 = trial voltage <= input
//   DAC_Ser_o      out  mirror-chain serial data
//   DAC_SClk_o     out  mirror-chain shift clock
//   DAC_LClk_o     out  mirror-chain latch strobe
//   result_o       out  last completed conversion (14 bits)
//   result_valid_o out  one-clock pulse when result_o updates
module pmod_adc_mirror #(
  parameter int CLK_DIV       = 1,
  parameter int SAMPLE_CYCLES = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic        pin_clk_i,
  input  logic        reset_ni,
  output logic        ADC_SH_o,
  output logic        ADC_Ser_o,
  output logic        ADC_SClk_o,
  output logic        ADC_LClk_o,
  input  logic        ADC_Comp_i,
  output logic        DAC_Ser_o,
  output logic        DAC_SClk_o,
  output logic        DAC_LClk_o,
  output logic [13:0] result_o,
  output logic        result_valid_o
);

  localparam int CNT_MAX_A = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > CLK_DIV) ? CNT_MAX_A : CLK_DIV;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_SAMPLE,
    S_TRIAL_SHIFT,
    S_TRIAL_LATCH,
    S_SETTLE,
    S_DECIDE,
    S_MIRROR_SHIFT,
    S_MIRROR_LATCH
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               phase_reg, phase_next;      // 0 = SClk low half, 1 = high half
  logic [3:0]         bit_cnt_reg, bit_cnt_next;  // bits already clocked in this frame
  logic [3:0]         bit_idx_reg, bit_idx_next;  // result bit under trial
  logic [13:0]        trial_reg, trial_next;      // decided bits plus current trial bit
  logic [15:0]        shift_reg, shift_next;      // frame word, current bit at [15]
  logic               sh_reg, sh_next;
  logic [13:0]        result_reg, result_next;
  logic               valid_reg, valid_next;
  logic [1:0]         comp_sync_reg;

  // Chain-independent frame levels; routed to whichever chain owns the next state.
  logic               frame_ser_next, frame_sclk_next, frame_lclk_next;
  logic               cur_ser, cur_sclk, cur_lclk;
  logic               to_adc;
  logic               adc_ser_reg, adc_sclk_reg, adc_lclk_reg;

`ifdef DAC_MIRROR_EN
  logic               to_dac;
  logic               dac_ser_reg, dac_sclk_reg, dac_lclk_reg;
  assign to_dac   = (state_next == S_MIRROR_SHIFT) || (state_next == S_MIRROR_LATCH);
  assign cur_ser  = adc_ser_reg  | dac_ser_reg;
  assign cur_sclk = adc_sclk_reg | dac_sclk_reg;
  assign cur_lclk = adc_lclk_reg | dac_lclk_reg;
  assign DAC_Ser_o  = dac_ser_reg;
  assign DAC_SClk_o = dac_sclk_reg;
  assign DAC_LClk_o = dac_lclk_reg;
`else
  assign cur_ser  = adc_ser_reg;
  assign cur_sclk = adc_sclk_reg;
  assign cur_lclk = adc_lclk_reg;
  assign DAC_Ser_o  = 1'b0;
  assign DAC_SClk_o = 1'b0;
  assign DAC_LClk_o = 1'b0;
`endif

  assign to_adc = (state_next == S_TRIAL_SHIFT) || (state_next == S_TRIAL_LATCH);

  assign ADC_SH_o       = sh_reg;
  assign ADC_Ser_o      = adc_ser_reg;
  assign ADC_SClk_o     = adc_sclk_reg;
  assign ADC_LClk_o     = adc_lclk_reg;
  assign result_o       = result_reg;
  assign result_valid_o = valid_reg;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    phase_next      = phase_reg;
    bit_cnt_next    = bit_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    trial_next      = trial_reg;
    shift_next      = shift_reg;
    sh_next         = sh_reg;
    result_next     = result_reg;
    valid_next      = 1'b0;
    frame_ser_next  = cur_ser;
    frame_sclk_next = cur_sclk;
    frame_lclk_next = cur_lclk;

    case (state_reg)
      S_SAMPLE: begin
        if (cnt_reg == SAMPLE_LAST) begin
          sh_next         = 1'b0;
          bit_idx_next    = 4'd13;
          trial_next      = 14'h2000;
          shift_next      = {14'h2000, 2'b00};
          state_next      = S_TRIAL_SHIFT;
          cnt_next        = '0;
          phase_next      = 1'b0;
          bit_cnt_next    = 4'd0;
          frame_ser_next  = shift_next[15];
          frame_sclk_next = 1'b0;
          frame_lclk_next = 1'b0;
        end else begin
          sh_next  = 1'b1;
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      S_TRIAL_SHIFT, S_MIRROR_SHIFT: begin
        if (cnt_reg != DIV_LAST) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          cnt_next = '0;
          if (!phase_reg) begin
            frame_sclk_next = 1'b1;
            phase_next      = 1'b1;
          end else begin
            // Ser moves on the same edge SClk falls, giving a full low half of setup.
            frame_sclk_next = 1'b0;
            phase_next      = 1'b0;
            if (bit_cnt_reg == 4'd15) begin
              frame_ser_next  = 1'b0;
              frame_lclk_next = 1'b1;
              state_next      = (state_reg == S_TRIAL_SHIFT) ? S_TRIAL_LATCH : S_MIRROR_LATCH;
            end else begin
              shift_next     = {shift_reg[14:0], shift_reg[15]};
              frame_ser_next = shift_reg[14];
              bit_cnt_next   = bit_cnt_reg + 4'd1;
            end
          end
        end
      end

      S_TRIAL_LATCH, S_MIRROR_LATCH: begin
        if (cnt_reg != DIV_LAST) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          frame_lclk_next = 1'b0;
          if (state_reg == S_TRIAL_LATCH) begin
            cnt_next   = '0;
            state_next = S_SETTLE;
          end else begin
            // Entering SAMPLE with SH already high, so count from 1.
            cnt_next   = CNT_W'(1);
            sh_next    = 1'b1;
            state_next = S_SAMPLE;
          end
        end
      end

      S_SETTLE: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next = '0;
          if (!comp_sync_reg[1]) begin
            trial_next[bit_idx_reg] = 1'b0;
          end
          state_next = S_DECIDE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      S_DECIDE: begin
        if (bit_idx_reg == 4'd0) begin
          result_next = trial_reg;
          valid_next  = 1'b1;
`ifdef DAC_MIRROR_EN
          shift_next      = {trial_reg, 2'b00};
          state_next      = S_MIRROR_SHIFT;
          cnt_next        = '0;
          phase_next      = 1'b0;
          bit_cnt_next    = 4'd0;
          frame_ser_next  = shift_next[15];
          frame_sclk_next = 1'b0;
          frame_lclk_next = 1'b0;
`else
          cnt_next   = CNT_W'(1);
          sh_next    = 1'b1;
          state_next = S_SAMPLE;
`endif
        end else begin
          bit_idx_next             = bit_idx_reg - 4'd1;
          trial_next[bit_idx_next] = 1'b1;
          shift_next               = {trial_next, 2'b00};
          state_next               = S_TRIAL_SHIFT;
          cnt_next                 = '0;
          phase_next               = 1'b0;
          bit_cnt_next             = 4'd0;
          frame_ser_next           = shift_next[15];
          frame_sclk_next          = 1'b0;
          frame_lclk_next          = 1'b0;
        end
      end

      default: state_next = S_SAMPLE;
    endcase
  end

  always_ff @(posedge pin_clk_i) begin
    if (!reset_ni) begin
      state_reg     <= S_SAMPLE;
      cnt_reg       <= '0;
      phase_reg     <= 1'b0;
      bit_cnt_reg   <= 4'd0;
      bit_idx_reg   <= 4'd0;
      trial_reg     <= 14'd0;
      shift_reg     <= 16'd0;
      sh_reg        <= 1'b0;
      result_reg    <= 14'd0;
      valid_reg     <= 1'b0;
      comp_sync_reg <= 2'b00;
      adc_ser_reg   <= 1'b0;
      adc_sclk_reg  <= 1'b0;
      adc_lclk_reg  <= 1'b0;
`ifdef DAC_MIRROR_EN
      dac_ser_reg   <= 1'b0;
      dac_sclk_reg  <= 1'b0;
      dac_lclk_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      phase_reg     <= phase_next;
      bit_cnt_reg   <= bit_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      trial_reg     <= trial_next;
      shift_reg     <= shift_next;
      sh_reg        <= sh_next;
      result_reg    <= result_next;
      valid_reg     <= valid_next;
      comp_sync_reg <= {comp_sync_reg[0], ADC_Comp_i};
      adc_ser_reg   <= frame_ser_next  & to_adc;
      adc_sclk_reg  <= frame_sclk_next & to_adc;
      adc_lclk_reg  <= frame_lclk_next & to_adc;
`ifdef DAC_MIRROR_EN
      dac_ser_reg   <= frame_ser_next  & to_dac;
      dac_sclk_reg  <= frame_sclk_next & to_dac;
      dac_lclk_reg  <= frame_lclk_next & to_dac;
`endif
    end
  end

endmodule

// File: tb/tb_pmod_adc_mirror.sv
// tb_pmod_adc_mirror
//   Self-checking bench for pmod_adc_mirror. Both serial chains are modelled
//   as 16-bit shift registers clocked on SClk rise and latched on LClk rise;
//   the comparator is (ADC latch <= vin). Expected trial words, results and
//   mirror words are queued when a conversion's input is chosen; a monitor
//   on the opposite clock edge pops and compares as the DUT produces them.
module tb_pmod_adc_mirror;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        adc_sh, adc_ser, adc_sclk, adc_lclk;
  logic        adc_comp = 1'b0;
  logic        dac_ser, dac_sclk, dac_lclk;
  logic [13:0] result;
  logic        result_valid;

  always #5 clk = ~clk;

  pmod_adc_mirror dut (
    .pin_clk_i      (clk),
    .reset_ni       (reset_ni),
    .ADC_SH_o       (adc_sh),
    .ADC_Ser_o      (adc_ser),
    .ADC_SClk_o     (adc_sclk),
    .ADC_LClk_o     (adc_lclk),
    .ADC_Comp_i     (adc_comp),
    .DAC_Ser_o      (dac_ser),
    .DAC_SClk_o     (dac_sclk),
    .DAC_LClk_o     (dac_lclk),
    .result_o       (result),
    .result_valid_o (result_valid)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] vin = 16'h0000;
  logic [15:0] adc_sr = 16'h0, adc_latched = 16'h0, dac_sr = 16'h0;
  int          adc_bits = 0, dac_bits = 0, latch_total = 0, results_seen = 0, dac_activity = 0;
  logic        p_adc_sclk = 0, p_adc_lclk = 0, p_adc_ser = 0;
  logic        p_dac_sclk = 0, p_dac_lclk = 0, p_dac_ser = 0, p_valid = 0;

  logic [15:0] trial_q[$];
  logic [13:0] result_q[$];
  logic [15:0] dac_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  // Reference: binary search over the 14-bit code; result is simply vin/4.
  task automatic start_conv(input logic [15:0] v);
    logic [13:0] r;
    logic [13:0] t;
    vin = v;
    r = 14'd0;
    for (int k = 13; k >= 0; k--) begin
      t = r | 14'(1 << k);
      trial_q.push_back({t, 2'b00});
      if ({t, 2'b00} <= v) r = t;
    end
    result_q.push_back(14'(v / 16'd4));
`ifdef DAC_MIRROR_EN
    dac_q.push_back(v & 16'hFFFC);
`endif
    $display("stimulus: vin=%04h expect result=%04h", v, v / 16'd4);
  endtask

  task automatic wait_result();
    int base;
    int n;
    base = results_seen;
    n = 0;
    while (results_seen == base && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("result_arrived", results_seen - base, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sh"}, adc_sh, 0);
    chk({tag, "_adc_ser"}, adc_ser, 0);
    chk({tag, "_adc_sclk"}, adc_sclk, 0);
    chk({tag, "_adc_lclk"}, adc_lclk, 0);
    chk({tag, "_dac_ser"}, dac_ser, 0);
    chk({tag, "_dac_sclk"}, dac_sclk, 0);
    chk({tag, "_dac_lclk"}, dac_lclk, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_valid"}, result_valid, 0);
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    if (adc_sclk || adc_lclk) chk("adc_sclk_lclk_overlap", adc_sclk & adc_lclk, 0);
    if (adc_sclk && !p_adc_sclk) begin
      chk("adc_ser_stable", adc_ser, p_adc_ser);
      chk("sh_low_in_trial", adc_sh, 0);
      adc_sr = {adc_sr[14:0], adc_ser};
      adc_bits++;
    end
    if (adc_lclk && !p_adc_lclk) begin
      chk("adc_bits_per_latch", adc_bits, 16);
      chk("sh_low_at_latch", adc_sh, 0);
      adc_latched = adc_sr;
      adc_bits = 0;
      latch_total++;
      if (trial_q.size() == 0) fail_event("unexpected_adc_latch");
      else begin
        logic [15:0] e;
        e = trial_q.pop_front();
        $display("adc latch: got %04h expected %04h", adc_latched, e);
        chk("adc_trial_word", adc_latched, e);
      end
    end
    adc_comp = (adc_latched <= vin);

`ifdef DAC_MIRROR_EN
    if (dac_sclk || dac_lclk) chk("dac_sclk_lclk_overlap", dac_sclk & dac_lclk, 0);
    if (dac_sclk && !p_dac_sclk) begin
      chk("dac_ser_stable", dac_ser, p_dac_ser);
      dac_sr = {dac_sr[14:0], dac_ser};
      dac_bits++;
    end
    if (dac_lclk && !p_dac_lclk) begin
      chk("dac_bits_per_latch", dac_bits, 16);
      dac_bits = 0;
      if (dac_q.size() == 0) fail_event("unexpected_dac_latch");
      else begin
        logic [15:0] e;
        e = dac_q.pop_front();
        $display("dac latch: got %04h expected %04h", dac_sr, e);
        chk("dac_mirror_word", dac_sr, e);
      end
    end
`else
    if (dac_ser || dac_sclk || dac_lclk) dac_activity++;
`endif

    if (result_valid) begin
      results_seen++;
      chk("valid_single_cycle", p_valid, 0);
      if (result_q.size() == 0) fail_event("unexpected_result");
      else begin
        logic [13:0] e;
        e = result_q.pop_front();
        $display("result: got %04h expected %04h", result, e);
        chk("result_value", result, e);
      end
    end

    p_adc_sclk = adc_sclk; p_adc_lclk = adc_lclk; p_adc_ser = adc_ser;
    p_dac_sclk = dac_sclk; p_dac_lclk = dac_lclk; p_dac_ser = dac_ser;
    p_valid = result_valid;
    if (!reset_ni) begin
      adc_bits = 0;
      dac_bits = 0;
    end
  end

  logic [15:0] vals[9];
  int          expected_results;

  initial begin
    vals[0] = 16'hFFFF;
    vals[1] = 16'h0000;
    vals[2] = 16'h2A52;
    vals[3] = 16'h1000;
    for (int i = 4; i < 9; i++) vals[i] = 16'($urandom_range(0, 65535));

    reset_ni = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset_state");

    start_conv(16'h2A52);
    expected_results = 1;
    reset_ni = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_result();
      start_conv(vals[i]);
      expected_results++;
    end
    wait_result();

    // Abort a conversion part-way through its trials.
    start_conv(16'h2A52);
    begin
      int base;
      int n;
      base = latch_total;
      n = 0;
      while (latch_total < base + 7 && n < 3000) begin
        @(posedge clk);
        n++;
      end
      chk("reach_trial_7", (latch_total >= base + 7) ? 1 : 0, 1);
    end
    repeat (10) @(posedge clk);
    #2;
    reset_ni = 1'b0;
    trial_q.delete();
    result_q.delete();
    dac_q.delete();
    @(posedge clk);
    #2;
    chk_all_zero("mid_reset");
    reset_ni = 1'b1;
    start_conv(16'h2A52);
    expected_results++;
    wait_result();

    repeat (45) @(posedge clk);
    #2;
    chk("queues_drained", trial_q.size() + result_q.size() + dac_q.size(), 0);
    chk("valid_pulse_count", results_seen, expected_results);
`ifndef DAC_MIRROR_EN
    chk("dac_outputs_idle", dac_activity, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
